// File: rtl/btb_fetch_unit_if.sv
// Icache and branch-resolution bus of the fetch front end.
// master = fetch unit side, slave = icache / MEM-stage side.
interface btb_fetch_unit_if;
    logic        ihit;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic [31:0] imemload;
    logic        res_valid;
    logic [31:0] res_pc;
    logic        res_taken;
    logic [31:0] res_target;
    logic        res_pred_taken;
    logic [31:0] res_pred_target;

    modport master (
        input  ihit, imemload,
        input  res_valid, res_pc, res_taken, res_target, res_pred_taken, res_pred_target,
        output imemREN, imemaddr
    );

    modport slave (
        output ihit, imemload,
        output res_valid, res_pc, res_taken, res_target, res_pred_taken, res_pred_target,
        input  imemREN, imemaddr
    );
endinterface

// File: rtl/btb_fetch_unit.sv
// Instruction-fetch front end: PC register, direct-mapped BTB with saturating
// counters, and redirect on mispredicts resolved in MEM.
module btb_fetch_unit #(
    parameter logic [31:0] PC_INIT     = 32'h0,
    parameter int          BTB_ENTRIES = 16,
    parameter int          CTR_BITS    = 2
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              pc_en,
    input  logic              halt,
    btb_fetch_unit_if.master  cif,
    output logic [31:0]       instr_if,
    output logic [31:0]       pc4_if,
    output logic              pred_taken_if,
    output logic [31:0]       pred_target_if,
    output logic              mispredict,
    output logic [31:0]       mispredict_cnt
);
    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = 30 - IDX;
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1) << (CTR_BITS - 1);
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_WT - CTR_BITS'(1);

    logic [31:0]         pc, pc_next;
    logic                valid  [BTB_ENTRIES];
    logic [CTR_BITS-1:0] ctr    [BTB_ENTRIES];
    logic [TAG_W-1:0]    tag    [BTB_ENTRIES];
    logic [31:0]         target [BTB_ENTRIES];

    logic [IDX-1:0]   idx, res_idx;
    logic [TAG_W-1:0] pc_tag, res_tag;
    logic             hit, res_hit;

    assign idx     = pc[IDX+1:2];
    assign pc_tag  = pc[31:IDX+2];
    assign res_idx = cif.res_pc[IDX+1:2];
    assign res_tag = cif.res_pc[31:IDX+2];

    assign hit     = valid[idx] && (tag[idx] == pc_tag);
    assign res_hit = valid[res_idx] && (tag[res_idx] == res_tag);

    assign pred_taken_if  = hit && ctr[idx][CTR_BITS-1];
    assign pred_target_if = pred_taken_if ? target[idx] : pc + 32'd4;

    assign mispredict = cif.res_valid &&
                        ((cif.res_taken != cif.res_pred_taken) ||
                         (cif.res_taken && (cif.res_target != cif.res_pred_target)));

    assign cif.imemREN  = 1'b1;
    assign cif.imemaddr = pc;
    assign instr_if     = cif.imemload;
    assign pc4_if       = pc + 32'd4;

    // Redirect beats halt, halt beats a normal advance.
    always_comb begin
        // NOTE: assign a default first so every path drives pc_next; otherwise always_comb infers a latch.
        pc_next = pc;
        if (mispredict)
            pc_next = cif.res_taken ? cif.res_target : cif.res_pc + 32'd4;
        else if (halt)
            pc_next = pc;
        else if (pc_en && cif.ihit)
            pc_next = pred_target_if;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!nRST) begin
            pc             <= PC_INIT;
            mispredict_cnt <= '0;
        end else begin
            pc <= pc_next;
            if (mispredict && (mispredict_cnt != 32'hFFFF_FFFF))
                mispredict_cnt <= mispredict_cnt + 32'd1;
        end
    end

    // Valid bits and counters carry architectural meaning, so they are reset.
    always_ff @(posedge CLK or negedge nRST) begin
        // NOTE: only valid/ctr arrays are reset; tag/target are masked by valid and live in a reset-free block.
        if (!nRST) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid[i] <= 1'b0;
                ctr[i]   <= CTR_WNT;
            end
        end else if (cif.res_valid) begin
            if (res_hit) begin
                if (cif.res_taken && (ctr[res_idx] != CTR_MAX))
                    ctr[res_idx] <= ctr[res_idx] + CTR_BITS'(1);
                else if (!cif.res_taken && (ctr[res_idx] != '0))
                    ctr[res_idx] <= ctr[res_idx] - CTR_BITS'(1);
            end else if (cif.res_taken) begin
                valid[res_idx] <= 1'b1;
                ctr[res_idx]   <= CTR_WT;
            end
        end
    end

    // A taken resolution always (re)writes tag and target: on a hit the tag is unchanged.
    always_ff @(posedge CLK) begin
        if (nRST && cif.res_valid && cif.res_taken) begin
            tag[res_idx]    <= res_tag;
            target[res_idx] <= cif.res_target;
        end
    end
endmodule

// File: tb/tb_btb_fetch_unit.sv
// Randomized scoreboard bench for btb_fetch_unit against a table-level
// model of the PC and BTB.
module tb_btb_fetch_unit;
    localparam logic [31:0] PC_INIT = 32'h0;
    localparam int N    = 16;
    localparam int CB   = 2;
    localparam int IDX  = $clog2(N);
    localparam int HALF = 1 << (CB - 1);
    localparam int CMAX = (1 << CB) - 1;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        pc_en, halt;
    logic [31:0] instr_if, pc4_if, pred_target_if, mispredict_cnt;
    logic        pred_taken_if, mispredict;

    btb_fetch_unit_if cif ();

    btb_fetch_unit #(.PC_INIT(PC_INIT), .BTB_ENTRIES(N), .CTR_BITS(CB)) dut (
        .CLK(CLK), .nRST(nRST), .pc_en(pc_en), .halt(halt), .cif(cif),
        .instr_if(instr_if), .pc4_if(pc4_if), .pred_taken_if(pred_taken_if),
        .pred_target_if(pred_target_if), .mispredict(mispredict),
        .mispredict_cnt(mispredict_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] pc, instr, pred_target, cnt;
        logic        pred_taken, mis;
    } exp_t;
    exp_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: a plain table of entries indexed by word address mod N.
    bit          m_valid [N];
    int          m_ctr   [N];
    logic [31:0] m_tag   [N];
    logic [31:0] m_tgt   [N];
    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0;
            m_ctr[i]   = HALF - 1;
        end
        m_pc  = PC_INIT;
        m_cnt = 0;
    endfunction

    function automatic void m_lookup(input logic [31:0] a, output bit tk, output logic [31:0] tg);
        int i = int'((a >> 2) % N);
        tk = m_valid[i] && (m_tag[i] == (a >> (2 + IDX))) && (m_ctr[i] >= HALF);
        tg = tk ? m_tgt[i] : a + 32'd4;
    endfunction

    function automatic bit m_mis();
        return cif.res_valid && ((cif.res_taken != cif.res_pred_taken) ||
               (cif.res_taken && cif.res_target != cif.res_pred_target));
    endfunction

    function automatic void model_step();
        bit          tk, mis;
        logic [31:0] tg;
        int          ri;
        mis = m_mis();
        m_lookup(m_pc, tk, tg);
        if (mis)                    m_pc = cif.res_taken ? cif.res_target : cif.res_pc + 32'd4;
        else if (halt)              m_pc = m_pc;
        else if (pc_en && cif.ihit) m_pc = tg;
        if (cif.res_valid) begin
            ri = int'((cif.res_pc >> 2) % N);
            if (m_valid[ri] && m_tag[ri] == (cif.res_pc >> (2 + IDX))) begin
                if (cif.res_taken) begin
                    m_ctr[ri] = (m_ctr[ri] + 1 > CMAX) ? CMAX : m_ctr[ri] + 1;
                    m_tgt[ri] = cif.res_target;
                end else begin
                    m_ctr[ri] = (m_ctr[ri] - 1 < 0) ? 0 : m_ctr[ri] - 1;
                end
            end else if (cif.res_taken) begin
                m_valid[ri] = 1;
                m_tag[ri]   = cif.res_pc >> (2 + IDX);
                m_tgt[ri]   = cif.res_target;
                m_ctr[ri]   = HALF;
            end
        end
        if (mis && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    endfunction

    // Push the expectation for the cycle as currently driven, then advance one edge.
    task automatic issue();
        exp_t e;
        bit   tk;
        logic [31:0] tg;
        if (!nRST) model_reset();
        m_lookup(m_pc, tk, tg);
        e.pc = m_pc; e.instr = cif.imemload; e.pred_taken = tk; e.pred_target = tg;
        e.mis = m_mis(); e.cnt = m_cnt;
        exp_q.push_back(e);
        @(posedge CLK);
        if (nRST) model_step();
        #1;
        cif.imemload = $urandom;
    endtask

    task automatic resolve(input logic [31:0] rpc, input bit tk, input logic [31:0] tgt,
                           input bit ptk, input logic [31:0] ptgt);
        cif.res_valid = 1'b1; cif.res_pc = rpc; cif.res_taken = tk;
        cif.res_target = tgt; cif.res_pred_taken = ptk; cif.res_pred_target = ptgt;
        issue();
        cif.res_valid = 1'b0;
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("imemaddr", cif.imemaddr, e.pc);
            check("imemREN", {31'b0, cif.imemREN}, 32'd1);
            check("pc4_if", pc4_if, e.pc + 32'd4);
            check("instr_if", instr_if, e.instr);
            check("pred_taken_if", {31'b0, pred_taken_if}, {31'b0, e.pred_taken});
            check("pred_target_if", pred_target_if, e.pred_target);
            check("mispredict", {31'b0, mispredict}, {31'b0, e.mis});
            check("mispredict_cnt", mispredict_cnt, e.cnt);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d expectations pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    logic [31:0] bpcs [6] = '{32'h10, 32'h50, 32'h20, 32'h60, 32'h100, 32'h34};
    logic [31:0] tgts [6] = '{32'h40, 32'h80, 32'h200, 32'hC, 32'h1000, 32'hFFFF_FFFC};

    initial begin
        bit          ptk;
        logic [31:0] ptgt, rpc;
        pc_en = 1'b1; halt = 1'b0;
        cif.ihit = 1'b1; cif.imemload = 32'h1234_5678;
        cif.res_valid = 1'b0; cif.res_pc = '0; cif.res_taken = 1'b0;
        cif.res_target = '0; cif.res_pred_taken = 1'b0; cif.res_pred_target = '0;
        model_reset();
        @(posedge CLK); #1;
        issue();                                   // held in reset
        nRST = 1'b1;
        repeat (4) issue();                        // 0,4,8,C -> PC now 0x10

        // Train 0x10 -> 0x40, then come back to 0x10 through a not-taken redirect at 0xC.
        resolve(32'h10, 1, 32'h40, 0, 32'h14);
        resolve(32'hC, 0, 32'h0, 1, 32'h80);
        #1 check("dir_pred_0x10", pred_target_if, 32'h40);
        issue();
        repeat (3) resolve(32'h10, 1, 32'h40, 1, 32'h40);
        resolve(32'h10, 0, 32'h0, 1, 32'h40);      // 3 -> 2, still taken
        resolve(32'hC, 0, 32'h0, 1, 32'h80);
        #1 check("dir_pred_sat", {31'b0, pred_taken_if}, 32'd1);
        issue();

        // Aliasing 0x50 replaces the idx-4 entry.
        resolve(32'h50, 1, 32'h80, 0, 32'h54);
        resolve(32'hC, 0, 32'h0, 1, 32'h80);
        #1 check("dir_alias", {31'b0, pred_taken_if}, 32'd0);
        issue();

        // Stall interaction.
        pc_en = 1'b0;
        resolve(32'h10, 1, 32'h200, 0, 32'h14);
        issue();
        pc_en = 1'b1; cif.ihit = 1'b0;
        repeat (2) issue();
        cif.ihit = 1'b1;

        // Halt, redirect through halt, then reset in the middle of an update.
        halt = 1'b1;
        issue();
        resolve(32'h20, 1, 32'h1000, 0, 32'h24);
        issue();
        resolve(32'h20, 1, 32'h1000, 1, 32'h1000);
        cif.res_valid = 1'b1; cif.res_pc = 32'h50; cif.res_taken = 1'b1;
        cif.res_target = 32'hC; cif.res_pred_taken = 1'b0;
        nRST = 1'b0;
        issue();
        cif.res_valid = 1'b0; halt = 1'b0; nRST = 1'b1;
        #1 check("dir_reset_cnt", mispredict_cnt, 32'd0);
        issue();
        resolve(32'h4C, 0, 32'h0, 1, 32'h80);     // back to 0x50: entry must be gone
        issue();

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            pc_en    = ($urandom_range(0, 9) < 8);
            cif.ihit = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 9) < 4) begin
                rpc = bpcs[$urandom_range(0, 5)];
                if ($urandom_range(0, 1) == 1) m_lookup(rpc, ptk, ptgt);
                else begin
                    ptk  = 1'($urandom_range(0, 1));
                    ptgt = tgts[$urandom_range(0, 5)];
                end
                resolve(rpc, 1'($urandom_range(0, 1)), tgts[$urandom_range(0, 5)], ptk, ptgt);
            end else begin
                issue();
            end
        end

        @(negedge CLK); #1;
        check("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
